// File: rtl/mem_stage_pkg.sv
// Shared types, exception cause codes and parameter defaults for the memory stage.
package mem_stage_pkg;

    localparam int DW_DEF      = 16;
    localparam int AW_DEF      = 12;
    localparam int SP_INIT_DEF = (2**AW_DEF) - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_UNDER = 2'b01;
    localparam logic [1:0] EXC_RANGE = 2'b10;
    localparam logic [1:0] EXC_OVER  = 2'b11;

endpackage

// File: rtl/pipelined_mem_stage_ram.sv
// Single-port DW x 2**AW RAM: synchronous write, registered (1-cycle) read.
module stage_ram
    import mem_stage_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pipelined_mem_stage.sv
// Memory stage: narrow/wide loads and stores, stack push/pop with SP, optional
// exception checking and EPC capture when MEMSTAGE_EXC_EN is defined.
//
// state   | meaning
// IDLE    | ready; accepted op issues beat 0 this cycle
// HI      | wide access, issuing beat 1 at address+1
// RESP    | o_valid high for one cycle with result
module pipelined_mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int SP_INIT = (2**AW) - 1
) (
    input  logic            clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic            i_wide,
    input  logic            i_is_stack,
    input  logic            i_push_pc,
    input  logic            i_epc_clear,
    input  logic [1:0]      i_wb,
    input  logic [DW-1:0]   i_alu_data,
    input  logic [2*DW-1:0] i_store_data,
    input  logic [2*DW-1:0] i_pc,
    input  logic [3:0]      i_flags,
    output logic            o_valid,
    output logic [1:0]      o_wb,
    output logic [DW-1:0]   o_alu_data,
    output logic [2*DW-1:0] o_mem_data,
    output logic [AW-1:0]   o_sp,
    output logic [2*DW-1:0] o_epc,
    output logic            o_exc,
    output logic [1:0]      o_exc_cause
);

    localparam logic [AW-1:0] SP_RST = AW'(SP_INIT);

    state_t          state;
    logic [AW-1:0]   sp, sp_pend, addr_hi, ram_addr;
    logic [DW-1:0]   wdata_hi, lo_q, ram_rdata, ram_wdata;
    logic            ram_we, read_q, write_q, wide_q;
    logic [2*DW-1:0] pc_q;

    logic            accept, access, two_beat, is_push, is_pop, fault;
    logic [1:0]      cause;
    logic [AW-1:0]   n_words, addr_a, sp_next;
    logic [2*DW-1:0] pc_plus1, wdata_full;

    assign o_ready  = (state == ST_IDLE);
    assign accept   = i_valid & o_ready;
    assign access   = i_mem_read | i_mem_write;
    assign two_beat = i_wide & access;
    assign is_push  = i_is_stack & i_mem_write;
    assign is_pop   = i_is_stack & i_mem_read & ~i_mem_write;
    assign n_words  = i_wide ? AW'(2) : AW'(1);
    assign addr_a   = !i_is_stack ? i_alu_data[AW-1:0] : (is_push ? sp - n_words : sp);
    assign sp_next  = is_push ? sp - n_words : (is_pop ? sp + n_words : sp);
    assign pc_plus1 = i_pc + (2*DW)'(1);
    // A pushed PC carries the CCR flags in its top nibble.
    assign wdata_full = i_push_pc ? {i_flags, pc_plus1[2*DW-5:0]} : i_store_data;
    assign o_sp     = sp;

`ifdef MEMSTAGE_EXC_EN
    logic [AW:0] sp_ext, n_ext;
    logic        range_err;

    assign sp_ext    = {1'b0, sp};
    assign n_ext     = {1'b0, n_words};
    assign range_err = access & ((~i_is_stack & ((i_alu_data >> AW) != '0))
                                 | (i_wide & (addr_a == '1)));

    always_comb begin
        cause = EXC_NONE;
        if (is_push && (sp_ext < n_ext))
            cause = EXC_OVER;
        else if (is_pop && ((sp_ext + n_ext) > (AW+1)'(SP_INIT)))
            cause = EXC_UNDER;
        else if (range_err)
            cause = EXC_RANGE;
    end
    assign fault = (cause != EXC_NONE);
`else
    assign cause = EXC_NONE;
    assign fault = 1'b0;
`endif

    stage_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Reset gates the write strobe so an aborted wide op never lands beat 1.
    always_comb begin
        ram_addr  = addr_a;
        ram_we    = 1'b0;
        ram_wdata = wdata_full[DW-1:0];
        if (state == ST_HI) begin
            ram_addr  = addr_hi;
            ram_we    = write_q;
            ram_wdata = wdata_hi;
        end else if (accept) begin
            ram_we = i_mem_write & ~fault;
        end
        if (i_reset) ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            sp         <= SP_RST;
            sp_pend    <= SP_RST;
            o_valid    <= 1'b0;
            o_wb       <= 2'b00;
            o_alu_data <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            wide_q     <= 1'b0;
            addr_hi    <= '0;
            wdata_hi   <= '0;
            lo_q       <= '0;
            pc_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        o_wb       <= fault ? 2'b00 : i_wb;
                        o_alu_data <= i_alu_data;
                        pc_q       <= i_pc;
                        read_q     <= i_mem_read & ~fault;
                        write_q    <= i_mem_write & ~fault;
                        wide_q     <= two_beat & ~fault;
                        addr_hi    <= addr_a + AW'(1);
                        wdata_hi   <= wdata_full[2*DW-1:DW];
                        if (two_beat && !fault) begin
                            state   <= ST_HI;
                            sp_pend <= sp_next;
                        end else begin
                            state   <= ST_RESP;
                            o_valid <= 1'b1;
                            if (!fault) sp <= sp_next;
                        end
                    end
                end
                ST_HI: begin
                    lo_q    <= ram_rdata;
                    sp      <= sp_pend;
                    state   <= ST_RESP;
                    o_valid <= 1'b1;
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    o_valid <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_mem_data = '0;
        if ((state == ST_RESP) && read_q)
            o_mem_data = wide_q ? {ram_rdata, lo_q} : {{DW{1'b0}}, ram_rdata};
    end

`ifdef MEMSTAGE_EXC_EN
    logic            exc_q;
    logic [1:0]      cause_q;
    logic [2*DW-1:0] epc_q;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            exc_q   <= 1'b0;
            cause_q <= EXC_NONE;
            epc_q   <= '0;
        end else begin
            if (accept) begin
                exc_q   <= fault;
                cause_q <= cause;
            end else if (state == ST_RESP) begin
                exc_q   <= 1'b0;
                cause_q <= EXC_NONE;
            end
            // A load in the same cycle as a clear takes priority.
            if ((state == ST_RESP) && exc_q)
                epc_q <= pc_q;
            else if (i_epc_clear)
                epc_q <= '0;
        end
    end

    assign o_exc       = exc_q;
    assign o_exc_cause = cause_q;
    assign o_epc       = epc_q;
`else
    logic unused_ok;
    assign unused_ok   = ^{i_epc_clear, pc_q, cause};
    assign o_exc       = 1'b0;
    assign o_exc_cause = EXC_NONE;
    assign o_epc       = '0;
`endif

endmodule

// File: tb/tb_pipelined_mem_stage.sv
// Directed table-driven bench for pipelined_mem_stage; exception expectations
// follow MEMSTAGE_EXC_EN.
module tb_pipelined_mem_stage;
    import mem_stage_pkg::*;

    localparam int DW = DW_DEF;
    localparam int AW = AW_DEF;

    localparam logic [4:0] RD = 5'b10000;
    localparam logic [4:0] WR = 5'b01000;
    localparam logic [4:0] WD = 5'b00100;
    localparam logic [4:0] SK = 5'b00010;
    localparam logic [4:0] PP = 5'b00001;
    localparam logic [4:0] NO = 5'b00000;

    logic            clk = 1'b0;
    logic            i_reset, i_valid, o_ready;
    logic            i_mem_read, i_mem_write, i_wide, i_is_stack, i_push_pc, i_epc_clear;
    logic [1:0]      i_wb, o_wb, o_exc_cause;
    logic [DW-1:0]   i_alu_data, o_alu_data;
    logic [2*DW-1:0] i_store_data, i_pc, o_mem_data, o_epc;
    logic [3:0]      i_flags;
    logic            o_valid, o_exc;
    logic [AW-1:0]   o_sp;

    always #5 clk = ~clk;

    pipelined_mem_stage dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_wide       (i_wide),
        .i_is_stack   (i_is_stack),
        .i_push_pc    (i_push_pc),
        .i_epc_clear  (i_epc_clear),
        .i_wb         (i_wb),
        .i_alu_data   (i_alu_data),
        .i_store_data (i_store_data),
        .i_pc         (i_pc),
        .i_flags      (i_flags),
        .o_valid      (o_valid),
        .o_wb         (o_wb),
        .o_alu_data   (o_alu_data),
        .o_mem_data   (o_mem_data),
        .o_sp         (o_sp),
        .o_epc        (o_epc),
        .o_exc        (o_exc),
        .o_exc_cause  (o_exc_cause)
    );

    typedef struct {
        logic [4:0]  ctl;
        logic [1:0]  wb;
        logic [15:0] alu;
        logic [31:0] sd;
        logic [31:0] pc;
        logic [3:0]  fl;
        int          lat;
        logic [31:0] md;
        logic [11:0] sp;
        logic [1:0]  ewb;
        logic        exc;
        logic [1:0]  cause;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_checks = 0;
    int   miscompares = 0;

    function automatic vec_t mk(input logic [4:0] ctl, input logic [1:0] wb,
                                input logic [15:0] alu, input logic [31:0] sd,
                                input logic [31:0] pc, input logic [3:0] fl,
                                input int lat, input logic [31:0] md,
                                input logic [11:0] sp, input logic [1:0] ewb,
                                input logic exc, input logic [1:0] cause);
        vec_t v;
        v.ctl = ctl; v.wb = wb; v.alu = alu; v.sd = sd; v.pc = pc; v.fl = fl;
        v.lat = lat; v.md = md; v.sp = sp; v.ewb = ewb; v.exc = exc; v.cause = cause;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        {i_mem_read, i_mem_write, i_wide, i_is_stack, i_push_pc} = v.ctl;
        i_wb = v.wb; i_alu_data = v.alu; i_store_data = v.sd;
        i_pc = v.pc; i_flags = v.fl; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 1;
        chk($sformatf("v%0d ready_busy", idx), {31'd0, o_ready}, 32'd0);
        while (!o_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d mem_data", idx), o_mem_data, v.md);
        chk($sformatf("v%0d sp", idx), {20'd0, o_sp}, {20'd0, v.sp});
        chk($sformatf("v%0d wb", idx), {30'd0, o_wb}, {30'd0, v.ewb});
        chk($sformatf("v%0d alu", idx), {16'd0, o_alu_data}, {16'd0, v.alu});
        chk($sformatf("v%0d exc", idx), {31'd0, o_exc}, {31'd0, v.exc});
        chk($sformatf("v%0d cause", idx), {30'd0, o_exc_cause}, {30'd0, v.cause});
        @(posedge clk); #1;
        chk($sformatf("v%0d valid_drop", idx), {31'd0, o_valid}, 32'd0);
        chk($sformatf("v%0d ready_back", idx), {31'd0, o_ready}, 32'd1);
        n_vec++;
    endtask

    initial begin
        i_reset = 1'b1; i_valid = 1'b0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_wide = 1'b0; i_is_stack = 1'b0;
        i_push_pc = 1'b0; i_epc_clear = 1'b0; i_wb = 2'b00; i_alu_data = '0;
        i_store_data = '0; i_pc = '0; i_flags = '0;

        //        ctl         wb     alu       sd            pc            fl      lat md            sp      ewb    exc   cause
        vecs.push_back(mk(WR,         2'b01, 16'h0010, 32'h0000_1234, 32'h0,        4'h0, 1, 32'h0,         12'hFFF, 2'b01, 1'b0, 2'b00));
        vecs.push_back(mk(RD,         2'b10, 16'h0010, 32'h0,         32'h0,        4'h0, 1, 32'h0000_1234, 12'hFFF, 2'b10, 1'b0, 2'b00));
        vecs.push_back(mk(WR|WD|SK,   2'b00, 16'h0000, 32'hDEAD_BEEF, 32'h0,        4'h0, 2, 32'h0,         12'hFFD, 2'b00, 1'b0, 2'b00));
        vecs.push_back(mk(RD|WD,      2'b11, 16'h0FFD, 32'h0,         32'h0,        4'h0, 2, 32'hDEAD_BEEF, 12'hFFD, 2'b11, 1'b0, 2'b00));
        vecs.push_back(mk(RD,         2'b01, 16'h0FFE, 32'h0,         32'h0,        4'h0, 1, 32'h0000_DEAD, 12'hFFD, 2'b01, 1'b0, 2'b00));
        vecs.push_back(mk(RD,         2'b01, 16'h0FFD, 32'h0,         32'h0,        4'h0, 1, 32'h0000_BEEF, 12'hFFD, 2'b01, 1'b0, 2'b00));
        vecs.push_back(mk(WR|WD|SK|PP,2'b00, 16'h0000, 32'h1234_5678, 32'h0000_0100,4'hA, 2, 32'h0,         12'hFFB, 2'b00, 1'b0, 2'b00));
        vecs.push_back(mk(RD|WD|SK,   2'b10, 16'h0000, 32'h0,         32'h0,        4'h0, 2, 32'hA000_0101, 12'hFFD, 2'b10, 1'b0, 2'b00));
        vecs.push_back(mk(RD|WD|SK,   2'b10, 16'h0000, 32'h0,         32'h0,        4'h0, 2, 32'hDEAD_BEEF, 12'hFFF, 2'b10, 1'b0, 2'b00));
        vecs.push_back(mk(NO|WD,      2'b11, 16'hABCD, 32'h0,         32'h0,        4'h0, 1, 32'h0,         12'hFFF, 2'b11, 1'b0, 2'b00));
        vecs.push_back(mk(WR|SK,      2'b01, 16'h0000, 32'h0000_5A5A, 32'h0,        4'h0, 1, 32'h0,         12'hFFE, 2'b01, 1'b0, 2'b00));
        vecs.push_back(mk(RD|SK,      2'b01, 16'h0000, 32'h0,         32'h0,        4'h0, 1, 32'h0000_5A5A, 12'hFFF, 2'b01, 1'b0, 2'b00));
        vecs.push_back(mk(WR|WD,      2'b00, 16'h0020, 32'h1111_2222, 32'h0,        4'h0, 2, 32'h0,         12'hFFF, 2'b00, 1'b0, 2'b00));
        vecs.push_back(mk(RD,         2'b01, 16'h0021, 32'h0,         32'h0,        4'h0, 1, 32'h0000_1111, 12'hFFF, 2'b01, 1'b0, 2'b00));
        vecs.push_back(mk(RD|WD,      2'b01, 16'h0020, 32'h0,         32'h0,        4'h0, 2, 32'h1111_2222, 12'hFFF, 2'b01, 1'b0, 2'b00));
`ifdef MEMSTAGE_EXC_EN
        vecs.push_back(mk(WR,         2'b01, 16'h0000, 32'h0000_1357, 32'h0,        4'h0, 1, 32'h0,         12'hFFF, 2'b01, 1'b0, 2'b00));
        vecs.push_back(mk(WR,         2'b01, 16'h1000, 32'h0000_7777, 32'h0000_1111,4'h0, 1, 32'h0,         12'hFFF, 2'b00, 1'b1, 2'b10));
        vecs.push_back(mk(RD,         2'b01, 16'h0000, 32'h0,         32'h0,        4'h0, 1, 32'h0000_1357, 12'hFFF, 2'b01, 1'b0, 2'b00));
        vecs.push_back(mk(WR|WD,      2'b01, 16'h0FFF, 32'h3333_4444, 32'h0000_2222,4'h0, 1, 32'h0,         12'hFFF, 2'b00, 1'b1, 2'b10));
        vecs.push_back(mk(RD|SK,      2'b11, 16'h0000, 32'h0,         32'h0000_4242,4'h0, 1, 32'h0,         12'hFFF, 2'b00, 1'b1, 2'b01));
`else
        vecs.push_back(mk(WR|WD,      2'b01, 16'h0FFF, 32'h3333_4444, 32'h0,        4'h0, 2, 32'h0,         12'hFFF, 2'b01, 1'b0, 2'b00));
        vecs.push_back(mk(RD,         2'b01, 16'h0000, 32'h0,         32'h0,        4'h0, 1, 32'h0000_3333, 12'hFFF, 2'b01, 1'b0, 2'b00));
        vecs.push_back(mk(WR,         2'b01, 16'h1000, 32'h0000_7777, 32'h0,        4'h0, 1, 32'h0,         12'hFFF, 2'b01, 1'b0, 2'b00));
        vecs.push_back(mk(RD,         2'b01, 16'h0000, 32'h0,         32'h0,        4'h0, 1, 32'h0000_7777, 12'hFFF, 2'b01, 1'b0, 2'b00));
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b0;
        chk("rst ready", {31'd0, o_ready}, 32'd1);
        chk("rst valid", {31'd0, o_valid}, 32'd0);
        chk("rst sp", {20'd0, o_sp}, SP_INIT_DEF);
        chk("rst mem_data", o_mem_data, 32'd0);
        chk("rst wb", {30'd0, o_wb}, 32'd0);
        chk("rst alu", {16'd0, o_alu_data}, 32'd0);
        chk("rst exc", {29'd0, o_exc, o_exc_cause}, 32'd0);
        chk("rst epc", o_epc, 32'd0);

        for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);

`ifdef MEMSTAGE_EXC_EN
        chk("epc load", o_epc, 32'h0000_4242);
        @(negedge clk); i_epc_clear = 1'b1;
        @(negedge clk); i_epc_clear = 1'b0;
        chk("epc clear", o_epc, 32'd0);
        i_epc_clear = 1'b1;
        run(mk(RD|SK, 2'b11, 16'h0000, 32'h0, 32'h0000_5555, 4'h0, 1, 32'h0, 12'hFFF, 2'b00, 1'b1, 2'b01), 100);
        i_epc_clear = 1'b0;
        chk("epc load beats clear", o_epc, 32'h0000_5555);
`else
        chk("epc tied", o_epc, 32'd0);
`endif

        // Reset while the high beat of a wide push is pending.
        @(negedge clk);
        {i_mem_read, i_mem_write, i_wide, i_is_stack, i_push_pc} = WR|WD|SK;
        i_wb = 2'b11; i_alu_data = 16'h0BAD; i_store_data = 32'h9999_8888; i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        chk("abort in_hi", {31'd0, o_ready}, 32'd0);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        chk("abort ready", {31'd0, o_ready}, 32'd1);
        chk("abort sp", {20'd0, o_sp}, 32'h0000_0FFF);
        chk("abort valid", {31'd0, o_valid}, 32'd0);
        chk("abort wb", {30'd0, o_wb}, 32'd0);
        chk("abort alu", {16'd0, o_alu_data}, 32'd0);
        n_vec++;
        run(mk(RD, 2'b01, 16'h0FFE, 32'h0, 32'h0, 4'h0, 1, 32'h0000_5A5A, 12'hFFF, 2'b01, 1'b0, 2'b00), 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
